// File: rtl/seg_pkg.sv
// Shared constants for the ASCII 7-segment scanner: segment patterns, ASCII codes, blink phase.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DASH    = 8'hFD;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;

  // Active-low {a,b,c,d,e,f,g,dp} for hex digits; element 0 is '0', element 15 is 'F'.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h61, 8'h85, 8'hE5, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/ascii_seg_rom.sv
// Combinational ASCII -> active-low segment decode; unknown codes map to blank.
module ascii_seg_rom
  import seg_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      segs = SEG_HEX[4'(ascii - 8'h30)];
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      segs = SEG_HEX[4'(ascii - 8'h37)];
    end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
      segs = SEG_HEX[4'(ascii - 8'h57)];
    end else if (ascii == ASCII_DASH) begin
      segs = SEG_DASH;
    end
  end

endmodule

// File: rtl/ascii_seg_scanner.sv
// Time-multiplexed 7-segment driver: ASCII character buffer, round-robin digit scan,
// per-digit decimal point and blink, and an all-off guard window at each slot start.
module ascii_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 500,
  parameter int BLINK_DIV  = 50,
  localparam int AW        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [7:0]            SEGS,
  output logic [NUM_DIGITS-1:0] DN,
  output logic [AW-1:0]         scan_idx
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0]         slot_cnt;
  logic [AW-1:0]         idx_q;
  logic [FW-1:0]         frame_cnt;
  blink_phase_e          phase_q;
  logic [7:0]            char_buf [NUM_DIGITS];
  logic [7:0]            segs_q;
  logic [NUM_DIGITS-1:0] dn_q;

  logic [7:0]            rom_segs;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] dn_next;
  logic                  slot_end;
  logic                  last_digit;
  logic                  in_guard;
  logic                  wr_ok;

  // Write port: wr_en is a fire-and-forget strobe with no ready; every strobed cycle
  // with an in-range wr_addr commits wr_data at that edge, out-of-range is dropped.
  assign wr_ok      = 32'(wr_addr) < NUM_DIGITS;
  assign slot_end   = (slot_cnt == CW'(SCAN_DIV - 1));
  assign last_digit = (idx_q == AW'(NUM_DIGITS - 1));
  assign in_guard   = (GUARD > 0) && (slot_cnt < CW'(GUARD));

  ascii_seg_rom u_rom (
    .ascii (char_buf[idx_q]),
    .segs  (rom_segs)
  );

  always_comb begin
    dn_next        = '1;
    dn_next[idx_q] = 1'b0;
    seg_next       = rom_segs;
    if (dp_mask[idx_q]) seg_next[0] = 1'b0;
    if (blink_mask[idx_q] && phase_q == BLINK_OFF) seg_next = SEG_BLANK;
    if (in_guard) begin
      seg_next = SEG_BLANK;
      dn_next  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      idx_q     <= '0;
      frame_cnt <= '0;
      phase_q   <= BLINK_ON;
      segs_q    <= SEG_BLANK;
      dn_q      <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) char_buf[i] <= ASCII_SPACE;
    end else begin
      if (wr_en && wr_ok) char_buf[wr_addr] <= wr_data;
      if (en) begin
        segs_q <= seg_next;
        dn_q   <= dn_next;
        if (slot_end) begin
          slot_cnt <= '0;
          idx_q    <= last_digit ? '0 : idx_q + 1'b1;
          // A frame completes when the last digit's slot ends.
          if (last_digit) begin
            if (frame_cnt == FW'(BLINK_DIV - 1)) begin
              frame_cnt <= '0;
              phase_q   <= (phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end else begin
        segs_q <= SEG_BLANK;
        dn_q   <= '1;
      end
    end
  end

  assign SEGS     = segs_q;
  assign DN       = dn_q;
  assign scan_idx = idx_q;

endmodule

// File: tb/tb_ascii_seg_scanner.sv
// Bench for ascii_seg_scanner: hand-derived vector table, corner sequences, and random
// stimulus checked against an arithmetic model of the scan timeline.
module tb_ascii_seg_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst, en, wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] dp_mask, blink_mask;
  logic [7:0] segs;
  logic [3:0] dn;
  logic [1:0] scan_idx;

  logic       wr5_en;
  logic [2:0] wr5_addr;
  logic [7:0] wr5_data;
  logic [4:0] dp5, blink5;
  logic [7:0] segs5;
  logic [4:0] dn5;
  logic [2:0] idx5;

  ascii_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .SEGS(segs), .DN(dn), .scan_idx(scan_idx)
  );

  ascii_seg_scanner #(.NUM_DIGITS(5), .SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr5_en), .wr_addr(wr5_addr), .wr_data(wr5_data),
    .dp_mask(dp5), .blink_mask(blink5), .SEGS(segs5), .DN(dn5), .scan_idx(idx5)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [13:0] exp_q[$];
  logic [7:0] mbuf [N];
  int         t;  // enabled cycles since reset

  typedef struct {
    logic [3:0] dn;
    logic [7:0] segs;
    logic [1:0] idx;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_decode(input logic [7:0] c);
    string      hexd = "0123456789abcdef";
    logic [7:0] pat [16];
    logic [7:0] lc;
    pat = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
            8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};
    lc = (c >= "A" && c <= "F") ? c + 8'h20 : c;
    ref_decode = 8'hFF;
    if (c == "-") ref_decode = 8'hFD;
    for (int i = 0; i < 16; i++) if (lc == hexd[i]) ref_decode = pat[i];
  endfunction

  // One clock: predict from the slot timeline, then compare after the edge.
  task automatic step();
    logic [7:0]  es;
    logic [3:0]  ed;
    logic [13:0] e;
    int          cnt, idx;
    bit          off;
    es = 8'hFF;
    ed = 4'hF;
    if (rst) begin
      for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
      t = 0;
    end else begin
      cnt = t % SD;
      idx = (t / SD) % N;
      off = (((t / (SD * N)) / BD) % 2) == 1;
      if (en && cnt >= GD) begin
        ed[idx] = 1'b0;
        es = ref_decode(mbuf[idx]);
        if (dp_mask[idx]) es[0] = 1'b0;
        if (blink_mask[idx] && off) es = 8'hFF;
      end
      if (wr_en) mbuf[wr_addr] = wr_data;
      if (en) t++;
    end
    exp_q.push_back({es, ed, 2'((t / SD) % N)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("segs", segs, e[13:6]);
    check("dn", dn, e[5:2]);
    check("scan_idx", scan_idx, e[1:0]);
  endtask

  // ---------------- drivers ----------------
  task automatic wr_char(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_3af();
    wr_char(2'd3, "3");
    wr_char(2'd2, "A");
    wr_char(2'd1, "-");
    wr_char(2'd0, "f");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int    hits, waited, held_idx, n;
    string cs = "0123456789ABCDEFabcdef-GzQ .";

    // "3A-f" scan after a fresh reset: guard cycle then 3 lit cycles per slot.
    tbl[0]  = '{4'b1111, 8'hFF, 2'd0}; tbl[1]  = '{4'b1110, 8'h71, 2'd0};
    tbl[2]  = '{4'b1110, 8'h71, 2'd0}; tbl[3]  = '{4'b1110, 8'h71, 2'd1};
    tbl[4]  = '{4'b1111, 8'hFF, 2'd1}; tbl[5]  = '{4'b1101, 8'hFD, 2'd1};
    tbl[6]  = '{4'b1101, 8'hFD, 2'd1}; tbl[7]  = '{4'b1101, 8'hFD, 2'd2};
    tbl[8]  = '{4'b1111, 8'hFF, 2'd2}; tbl[9]  = '{4'b1011, 8'h11, 2'd2};
    tbl[10] = '{4'b1011, 8'h11, 2'd2}; tbl[11] = '{4'b1011, 8'h11, 2'd3};
    tbl[12] = '{4'b1111, 8'hFF, 2'd3}; tbl[13] = '{4'b0111, 8'h0D, 2'd3};
    tbl[14] = '{4'b0111, 8'h0D, 2'd3}; tbl[15] = '{4'b0111, 8'h0D, 2'd0};

    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dp_mask = '0; blink_mask = '0;
    wr5_en = 1'b0; wr5_addr = '0; wr5_data = '0; dp5 = '0; blink5 = '0;
    step();
    do_reset();
    check("rst_segs", segs, 8'hFF);
    check("rst_dn", dn, 4'hF);

    // 1: empty buffer stays blank while scanning; reset mid-scan
    en = 1'b1;
    repeat (41) begin
      step();
      check("blank_segs", segs, 8'hFF);
    end
    do_reset();
    check("midrst_segs", segs, 8'hFF);
    check("midrst_dn", dn, 4'hF);
    check("midrst_idx", scan_idx, 2'd0);

    // 2: table-driven "3A-f", two periods
    en = 1'b0;
    load_3af();
    en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        step();
        check("tbl_dn", dn, tbl[i].dn);
        check("tbl_segs", segs, tbl[i].segs);
        check("tbl_idx", scan_idx, tbl[i].idx);
      end
    end

    // 3: decimal point on digit 1 showing '8'
    dp_mask = 4'b0010;
    wr_char(2'd1, "8");
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dn == 4'b1101) begin
        check("dp_segs", segs, 8'h00);
        hits++;
      end
      if (dn == 4'b1110) check("dp_other", segs, 8'h71);
    end
    check("dp_hits", hits, 3);
    dp_mask = '0;

    // 4: blink digit 0; on for two frames, off for two
    do_reset();
    en = 1'b0;
    load_3af();
    blink_mask = 4'b0001;
    en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (dn == 4'b1110) check("blink_segs", segs, (k - 1) < 32 ? 8'h71 : 8'hFF);
    end
    blink_mask = '0;

    // 5a: write into the digit on display
    waited = 0;
    while (!(dn == 4'hF && scan_idx == 2'd1) && waited < 64) begin
      step();
      waited++;
    end
    check("wait_slot1", waited < 64, 1);
    step();
    wr_char(2'd1, "7");
    check("wr_old_segs", segs, 8'hFD);
    step();
    check("wr_live_segs", segs, 8'h1F);
    check("wr_live_dn", dn, 4'b1101);

    // 5b: five-digit build drops out-of-range addresses
    wr5_en = 1'b1;
    wr5_data = "8";
    for (int a = 5; a < 8; a++) begin
      wr5_addr = 3'(a);
      step();
    end
    wr5_addr = 3'd4;
    wr5_data = "1";
    step();
    wr5_en = 1'b0;
    hits = 0;
    repeat (40) begin
      step();
      if (dn5 == 5'b01111) begin
        check("d5_slot4", segs5, 8'h9F);
        hits++;
      end else begin
        check("d5_blank", segs5, 8'hFF);
      end
    end
    check("d5_hits", hits > 0, 1);

    // 6: drop en mid-slot for 10 cycles, resume with the slot remainder intact
    waited = 0;
    while ((t % SD) != 2 && waited < 16) begin
      step();
      waited++;
    end
    held_idx = scan_idx;
    en = 1'b0;
    repeat (10) begin
      step();
      check("hold_segs", segs, 8'hFF);
      check("hold_dn", dn, 4'hF);
      check("hold_idx", scan_idx, held_idx);
    end
    en = 1'b1;
    n = 0;
    while (scan_idx == 2'(held_idx) && n < 20) begin
      step();
      n++;
    end
    check("resume_len", n, 2);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cs[$urandom_range(0, cs.len() - 1)];
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
